// File: rtl/data_bus_ctrl.sv
// Master-to-device bus bridge: decodes the top address bits into a device
// select, strobes the selected device until its waitrequest drops (or a
// stall timeout expires) and returns a one-cycle completion pulse.
module data_bus_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int SEL_W   = 4,
  parameter int NUM_DEV = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      ReadData,
  input  logic                      WriteData,
  input  logic [ADDR_W-1:0]         DataAddr,
  input  logic [DATA_W-1:0]         BusIn,
  output logic [DATA_W-1:0]         BusOut,
  output logic                      DataDone,
  output logic                      DataErr,
  output logic [NUM_DEV-1:0]        dev_read,
  output logic [NUM_DEV-1:0]        dev_write,
  output logic [ADDR_W-SEL_W-1:0]   dev_addr,
  output logic [DATA_W-1:0]         dev_wdata,
  input  logic [NUM_DEV*DATA_W-1:0] dev_rdata,
  input  logic [NUM_DEV-1:0]        dev_waitreq
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t             state, state_next;
  logic [SEL_W-1:0]   sel_q;
  logic               is_write_q;
  logic               err_q;
  logic [CNT_W-1:0]   stall_cnt;

  logic [SEL_W-1:0]   req_sel;
  logic               req_valid_sel;
  logic               req_bad;
  logic [NUM_DEV-1:0] req_onehot;
  logic [DATA_W-1:0]  rd_sel;
  logic               wait_sel;

  logic [NUM_DEV-1:0] read_next, write_next;
  logic               done_next, err_next;
  logic               latch, complete, timeout;

  // Decode the incoming request and mux the selected device's response.
  always_comb begin
    req_sel       = DataAddr[ADDR_W-1 -: SEL_W];
    req_valid_sel = ({1'b0, req_sel} < (SEL_W+1)'(NUM_DEV));
    req_bad       = !req_valid_sel || (ReadData && WriteData);
    req_onehot    = '0;
    rd_sel        = '0;
    wait_sel      = 1'b0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      req_onehot[i] = (req_sel == SEL_W'(i));
      if (sel_q == SEL_W'(i)) begin
        rd_sel   = dev_rdata[i*DATA_W +: DATA_W];
        wait_sel = dev_waitreq[i];
      end
    end
  end

  // Next-state logic and next values of the registered strobes/status.
  always_comb begin
    state_next = state;
    read_next  = '0;
    write_next = '0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    latch      = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        // DataDone is still high in the first IDLE cycle; the master has not
        // yet dropped its held request, so it must not start a new access.
        if ((ReadData || WriteData) && !DataDone) begin
          latch = 1'b1;
          if (req_bad) begin
            state_next = RESP;
          end else begin
            state_next = ACCESS;
            read_next  = ReadData  ? req_onehot : '0;
            write_next = WriteData ? req_onehot : '0;
          end
        end
      end
      ACCESS: begin
        if (!wait_sel) begin
          complete   = 1'b1;
          state_next = RESP;
        end else if (stall_cnt == CNT_W'(TIMEOUT - 1)) begin
          timeout    = 1'b1;
          state_next = RESP;
        end else begin
          read_next  = dev_read;
          write_next = dev_write;
        end
      end
      RESP: begin
        done_next  = 1'b1;
        err_next   = err_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus latched transaction fields and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      sel_q      <= '0;
      is_write_q <= 1'b0;
      err_q      <= 1'b0;
      stall_cnt  <= '0;
      dev_read   <= '0;
      dev_write  <= '0;
      DataDone   <= 1'b0;
      DataErr    <= 1'b0;
      BusOut     <= '0;
      dev_addr   <= '0;
      dev_wdata  <= '0;
    end else begin
      state     <= state_next;
      dev_read  <= read_next;
      dev_write <= write_next;
      DataDone  <= done_next;
      DataErr   <= err_next;
      if (state == ACCESS && wait_sel) begin
        stall_cnt <= stall_cnt + 1'b1;
      end else begin
        stall_cnt <= '0;
      end
      if (latch) begin
        dev_addr   <= DataAddr[ADDR_W-SEL_W-1:0];
        dev_wdata  <= BusIn;
        sel_q      <= req_sel;
        is_write_q <= WriteData;
        err_q      <= req_bad;
      end
      if (complete && !is_write_q) begin
        BusOut <= rd_sel;
      end
      if (timeout) begin
        BusOut <= '1;
        err_q  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Directed bench for data_bus_ctrl: reads, stalled writes, bad selects,
// timeout, conflicting requests and reset during an access.
module tb_data_bus_ctrl;

    logic        Clock;
    logic        Reset;
    logic        ReadData;
    logic        WriteData;
    logic [15:0] DataAddr;
    logic [15:0] BusIn;
    logic [15:0] BusOut;
    logic        DataDone;
    logic        DataErr;
    logic [3:0]  dev_read;
    logic [3:0]  dev_write;
    logic [11:0] dev_addr;
    logic [15:0] dev_wdata;
    logic [63:0] dev_rdata;
    logic [3:0]  dev_waitreq;

    int checks = 0;
    int errors = 0;

    data_bus_ctrl #(
        .DATA_W (16),
        .ADDR_W (16),
        .SEL_W  (4),
        .NUM_DEV(4),
        .TIMEOUT(8)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .ReadData   (ReadData),
        .WriteData  (WriteData),
        .DataAddr   (DataAddr),
        .BusIn      (BusIn),
        .BusOut     (BusOut),
        .DataDone   (DataDone),
        .DataErr    (DataErr),
        .dev_read   (dev_read),
        .dev_write  (dev_write),
        .dev_addr   (dev_addr),
        .dev_wdata  (dev_wdata),
        .dev_rdata  (dev_rdata),
        .dev_waitreq(dev_waitreq)
    );

    // Free-running clock.
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Directed stimulus; inputs change and outputs are sampled on the falling edge.
    initial begin
        Reset       = 1'b1;
        ReadData    = 1'b0;
        WriteData   = 1'b0;
        DataAddr    = '0;
        BusIn       = '0;
        dev_rdata   = '0;
        dev_waitreq = '0;
        repeat (2) @(negedge Clock);
        check("rst_busout", 32'(BusOut), 32'h0);
        check("rst_done", 32'(DataDone), 32'h0);
        check("rst_err", 32'(DataErr), 32'h0);
        check("rst_strobes", 32'({dev_read, dev_write}), 32'h0);
        check("rst_addr", 32'(dev_addr), 32'h0);
        check("rst_wdata", 32'(dev_wdata), 32'h0);
        Reset = 1'b0;
        @(negedge Clock);

        // Zero-wait read from device 1.
        ReadData = 1'b1;
        DataAddr = 16'h1004;
        dev_rdata[16 +: 16] = 16'hBEEF;
        @(negedge Clock);
        check("rd1_strobe", 32'(dev_read), 32'h2);
        check("rd1_nowrite", 32'(dev_write), 32'h0);
        check("rd1_addr", 32'(dev_addr), 32'h004);
        check("rd1_done_early", 32'(DataDone), 32'h0);
        @(negedge Clock);
        check("rd1_strobe_off", 32'(dev_read), 32'h0);
        check("rd1_done_resp", 32'(DataDone), 32'h0);
        check("rd1_err_low", 32'(DataErr), 32'h0);
        @(negedge Clock);
        check("rd1_done", 32'(DataDone), 32'h1);
        check("rd1_err", 32'(DataErr), 32'h0);
        check("rd1_busout", 32'(BusOut), 32'hBEEF);
        ReadData = 1'b0;
        @(negedge Clock);
        check("rd1_done_pulse", 32'(DataDone), 32'h0);

        // Write to device 0 stalled for three cycles.
        WriteData = 1'b1;
        DataAddr  = 16'h0020;
        BusIn     = 16'h1234;
        dev_waitreq[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            check("wr0_strobe", 32'(dev_write), 32'h1);
            check("wr0_noread", 32'(dev_read), 32'h0);
            check("wr0_done_low", 32'(DataDone), 32'h0);
            if (i == 0) begin
                DataAddr = 16'h3FFF;
                BusIn    = 16'h5555;
            end
            if (i == 3) dev_waitreq[0] = 1'b0;
        end
        check("wr0_wdata", 32'(dev_wdata), 32'h1234);
        check("wr0_addr_held", 32'(dev_addr), 32'h020);
        @(negedge Clock);
        check("wr0_strobe_off", 32'(dev_write), 32'h0);
        check("wr0_done_resp", 32'(DataDone), 32'h0);
        @(negedge Clock);
        check("wr0_done", 32'(DataDone), 32'h1);
        check("wr0_err", 32'(DataErr), 32'h0);
        check("wr0_busout", 32'(BusOut), 32'hBEEF);
        WriteData = 1'b0;
        @(negedge Clock);

        // Read with select 7, beyond the attached devices.
        ReadData = 1'b1;
        DataAddr = 16'h7000;
        @(negedge Clock);
        check("bad_strobes", 32'({dev_read, dev_write}), 32'h0);
        check("bad_done_early", 32'(DataDone), 32'h0);
        check("bad_err_low", 32'(DataErr), 32'h0);
        @(negedge Clock);
        check("bad_done", 32'(DataDone), 32'h1);
        check("bad_err", 32'(DataErr), 32'h1);
        ReadData = 1'b0;
        @(negedge Clock);

        // Read from device 3: checks the top slice of the read data bus.
        ReadData = 1'b1;
        DataAddr = 16'h3ABC;
        dev_rdata[48 +: 16] = 16'hCAFE;
        @(negedge Clock);
        check("rd3_strobe", 32'(dev_read), 32'h8);
        check("rd3_addr", 32'(dev_addr), 32'hABC);
        @(negedge Clock);
        @(negedge Clock);
        check("rd3_done", 32'(DataDone), 32'h1);
        check("rd3_busout", 32'(BusOut), 32'hCAFE);
        ReadData = 1'b0;
        @(negedge Clock);

        // Read from device 2 with waitrequest stuck high.
        ReadData = 1'b1;
        DataAddr = 16'h2000;
        dev_waitreq[2] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            check("to_strobe", 32'(dev_read), 32'h4);
            check("to_done_low", 32'(DataDone), 32'h0);
        end
        @(negedge Clock);
        check("to_strobe_off", 32'(dev_read), 32'h0);
        check("to_busout_resp", 32'(BusOut), 32'hFFFF);
        @(negedge Clock);
        check("to_done", 32'(DataDone), 32'h1);
        check("to_err", 32'(DataErr), 32'h1);
        check("to_busout", 32'(BusOut), 32'hFFFF);
        ReadData = 1'b0;
        dev_waitreq[2] = 1'b0;
        @(negedge Clock);

        // Simultaneous read and write request.
        ReadData  = 1'b1;
        WriteData = 1'b1;
        DataAddr  = 16'h1000;
        @(negedge Clock);
        check("both_strobes", 32'({dev_read, dev_write}), 32'h0);
        @(negedge Clock);
        check("both_done", 32'(DataDone), 32'h1);
        check("both_err", 32'(DataErr), 32'h1);
        check("both_busout", 32'(BusOut), 32'hFFFF);
        ReadData  = 1'b0;
        WriteData = 1'b0;
        @(negedge Clock);

        // Reset during the second ACCESS cycle of a stalled write.
        WriteData = 1'b1;
        DataAddr  = 16'h1055;
        BusIn     = 16'hA5A5;
        dev_waitreq[1] = 1'b1;
        @(negedge Clock);
        check("rstacc_strobe1", 32'(dev_write), 32'h2);
        @(negedge Clock);
        check("rstacc_strobe2", 32'(dev_write), 32'h2);
        Reset = 1'b1;
        @(negedge Clock);
        check("rstacc_strobe_off", 32'({dev_read, dev_write}), 32'h0);
        check("rstacc_done", 32'(DataDone), 32'h0);
        check("rstacc_busout", 32'(BusOut), 32'h0);
        check("rstacc_wdata", 32'(dev_wdata), 32'h0);
        Reset     = 1'b0;
        WriteData = 1'b0;
        dev_waitreq[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            check("rstacc_no_done", 32'(DataDone), 32'h0);
            check("rstacc_idle", 32'({dev_read, dev_write}), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
